// File: rtl/dlx_pkg.sv
// rtl/dlx_pkg.sv - shared constants and FSM encoding for the DLX trap controller
package dlx_pkg;

   localparam int unsigned DLX_IRQ_W   = 8;
   localparam int unsigned DLX_CAUSE_W = 3;

   localparam logic [31:0] DLX_VEC_BASE = 32'h0000_0100;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PENDING = 3'd1,
      ST_SAVE    = 3'd2,
      ST_VECTOR  = 3'd3,
      ST_SERVICE = 3'd4
   } dlx_state_e;

endpackage

// File: rtl/dlx_prio_enc8.sv
// rtl/dlx_prio_enc8.sv - 8-bit priority encoder, bit 0 wins
module dlx_prio_enc8
   import dlx_pkg::*;
(
   input  logic [DLX_IRQ_W-1:0]   in_vec,
   output logic [DLX_CAUSE_W-1:0] idx,
   output logic                   valid
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx   = '0;
      valid = |in_vec;
      for (int i = DLX_IRQ_W - 1; i >= 0; i--) begin
         if (in_vec[i]) begin
            idx = DLX_CAUSE_W'(i);
         end
      end
   end

endmodule

// File: rtl/dlx_trap_ctrl.sv
// rtl/dlx_trap_ctrl.sv - interrupt mask, trap sequencing FSM and vector generation
module dlx_trap_ctrl
   import dlx_pkg::*;
#(
   parameter logic [31:0] VEC_BASE        = DLX_VEC_BASE,
   parameter int unsigned VEC_STRIDE_LOG2 = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [DLX_IRQ_W-1:0]   irq,
   input  logic                   mask_load,
   input  logic [31:0]            dest_bus,
   input  logic                   instr_done,
   input  logic [31:0]            pc_in,
   input  logic                   int_ack,
   input  logic                   rfe,
   output logic                   int_req,
   output logic [31:0]            iar_wdata,
   output logic                   IAR_load,
   output logic [31:0]            pc_wdata,
   output logic                   pc_load,
   output logic [DLX_CAUSE_W-1:0] cause,
   output logic                   in_service
);

   dlx_state_e             state_q, state_d;
   logic [DLX_IRQ_W-1:0]   mask_q, mask_d;
   logic [DLX_CAUSE_W-1:0] cause_q, cause_d;

   logic [DLX_IRQ_W-1:0]   pend_vec;
   logic [DLX_CAUSE_W-1:0] pend_idx;
   logic                   pend_valid;
   logic [31:0]            vec_addr;
   logic                   unused_dest_hi;

   assign unused_dest_hi = ^dest_bus[31:DLX_IRQ_W];

   // The old mask gates entry even when a new one is loaded on the same edge.
   assign pend_vec = irq & mask_q;

   dlx_prio_enc8 u_prio_enc (
      .in_vec (pend_vec),
      .idx    (pend_idx),
      .valid  (pend_valid)
   );

   assign vec_addr = VEC_BASE + ({{(32-DLX_CAUSE_W){1'b0}}, cause_q} << VEC_STRIDE_LOG2);
   assign cause    = cause_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         mask_q  <= '0;
         cause_q <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         cause_q <= cause_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      mask_d     = mask_load ? dest_bus[DLX_IRQ_W-1:0] : mask_q;
      cause_d    = cause_q;
      int_req    = 1'b0;
      IAR_load   = 1'b0;
      iar_wdata  = '0;
      pc_load    = 1'b0;
      pc_wdata   = '0;
      in_service = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (instr_done && pend_valid) begin
               state_d = ST_PENDING;
               cause_d = pend_idx;
            end
         end
         ST_PENDING: begin
            int_req = 1'b1;
            if (int_ack) begin
               state_d = ST_SAVE;
            end
         end
         ST_SAVE: begin
            IAR_load  = 1'b1;
            iar_wdata = pc_in;
            state_d   = ST_VECTOR;
         end
         ST_VECTOR: begin
            pc_load  = 1'b1;
            pc_wdata = vec_addr;
            state_d  = ST_SERVICE;
         end
         ST_SERVICE: begin
            in_service = 1'b1;
            if (rfe) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dlx_trap_ctrl.sv
// tb/tb_dlx_trap_ctrl.sv - randomized and directed bench for dlx_trap_ctrl
module tb_dlx_trap_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  irq;
   logic        mask_load;
   logic [31:0] dest_bus;
   logic        instr_done;
   logic [31:0] pc_in;
   logic        int_ack;
   logic        rfe;
   logic        int_req;
   logic [31:0] iar_wdata;
   logic        IAR_load;
   logic [31:0] pc_wdata;
   logic        pc_load;
   logic [2:0]  cause;
   logic        in_service;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: where we are in the trap sequence, plus mask and cause
   localparam int M_IDLE = 0, M_WAIT_ACK = 1, M_SAVE_PC = 2, M_JUMP = 3, M_HANDLER = 4;
   int          m_stage;
   logic [7:0]  m_mask;
   int          m_cause;

   dlx_trap_ctrl dut (
      .clock      (clock),
      .reset      (reset),
      .irq        (irq),
      .mask_load  (mask_load),
      .dest_bus   (dest_bus),
      .instr_done (instr_done),
      .pc_in      (pc_in),
      .int_ack    (int_ack),
      .rfe        (rfe),
      .int_req    (int_req),
      .iar_wdata  (iar_wdata),
      .IAR_load   (IAR_load),
      .pc_wdata   (pc_wdata),
      .pc_load    (pc_load),
      .cause      (cause),
      .in_service (in_service)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_stage = M_IDLE;
      m_mask  = 8'h00;
      m_cause = 0;
   endtask

   task automatic model_update();
      logic [7:0] live;
      live = irq & m_mask;
      case (m_stage)
         M_IDLE: begin
            if (instr_done && live != 8'h00) begin
               for (int i = 0; i < 8; i++) begin
                  if (live[i]) begin
                     m_cause = i;
                     break;
                  end
               end
               m_stage = M_WAIT_ACK;
            end
         end
         M_WAIT_ACK: if (int_ack) m_stage = M_SAVE_PC;
         M_SAVE_PC:  m_stage = M_JUMP;
         M_JUMP:     m_stage = M_HANDLER;
         M_HANDLER:  if (rfe) m_stage = M_IDLE;
         default:    m_stage = M_IDLE;
      endcase
      if (mask_load) m_mask = dest_bus[7:0];
   endtask

   task automatic check_outputs();
      logic [31:0] exp_iar, exp_pc;
      exp_iar = (m_stage == M_SAVE_PC) ? pc_in : 32'h0;
      exp_pc  = (m_stage == M_JUMP) ? 32'h0000_0100 + 32'(m_cause) * 32'd16 : 32'h0;
      check("int_req",    32'(int_req),    32'(m_stage == M_WAIT_ACK));
      check("IAR_load",   32'(IAR_load),   32'(m_stage == M_SAVE_PC));
      check("iar_wdata",  iar_wdata,       exp_iar);
      check("pc_load",    32'(pc_load),    32'(m_stage == M_JUMP));
      check("pc_wdata",   pc_wdata,        exp_pc);
      check("cause",      32'(cause),      32'(m_cause));
      check("in_service", 32'(in_service), 32'(m_stage == M_HANDLER));
   endtask

   task automatic drive(input logic [7:0] i_irq, input logic i_ml, input logic [31:0] i_dest,
                        input logic i_done, input logic i_ack, input logic i_rfe);
      irq        = i_irq;
      mask_load  = i_ml;
      dest_bus   = i_dest;
      instr_done = i_done;
      int_ack    = i_ack;
      rfe        = i_rfe;
      pc_in      = $urandom;
   endtask

   task automatic cycle();
      @(posedge clock);
      model_update();
      @(negedge clock);
      check_outputs();
   endtask

   task automatic async_reset(input string tag);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check({tag, "_int_req"},  32'(int_req),  32'h0);
      check({tag, "_IAR_load"}, 32'(IAR_load), 32'h0);
      check({tag, "_iar"},      iar_wdata,     32'h0);
      check({tag, "_pc_load"},  32'(pc_load),  32'h0);
      check({tag, "_pc"},       pc_wdata,      32'h0);
      check({tag, "_cause"},    32'(cause),    32'h0);
      check({tag, "_svc"},      32'(in_service), 32'h0);
      check({tag, "_mask"},     32'(dut.mask_q), 32'h0);
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      model_reset();
      drive(8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      check_outputs();

      // mask still clear after reset: nothing is taken
      for (int k = 0; k < 10; k++) begin
         drive(8'hFF, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
         cycle();
         drive(8'hFF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
         cycle();
         check("masked_no_req", 32'(int_req), 32'h0);
      end

      // rfe and int_ack in idle do nothing
      drive(8'h00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      cycle();
      check("idle_ack_rfe_strobes", 32'({int_req, IAR_load, pc_load, in_service}), 32'h0);

      // mask load coincident with instr_done sees the old (zero) mask
      drive(8'hFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      cycle();
      check("old_mask_used", 32'(int_req), 32'h0);

      // irq 0010_0100 -> cause 2 -> vector 0x120
      drive(8'b0010_0100, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      cycle();
      check("pend_req", 32'(int_req), 32'h1);
      check("pend_cause", 32'(cause), 32'h2);
      drive(8'h00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      cycle();
      check("save_strobe", 32'(IAR_load), 32'h1);
      check("save_iar_pc", iar_wdata, pc_in);
      drive(8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      cycle();
      check("vec_strobe", 32'(pc_load), 32'h1);
      check("vec_addr_120", pc_wdata, 32'h0000_0120);
      cycle();
      check("in_service", 32'(in_service), 32'h1);

      // no nesting while in service
      drive(8'h01, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      cycle();
      check("no_nest", 32'(int_req), 32'h0);
      drive(8'h01, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      cycle();
      drive(8'h01, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      cycle();
      check("after_rfe_req", 32'(int_req), 32'h1);
      check("after_rfe_cause", 32'(cause), 32'h0);

      // pending holds without ack while irq wiggles
      for (int k = 0; k < 5; k++) begin
         drive(8'($urandom), 1'b0, 32'h0, 1'($urandom), 1'b0, 1'($urandom));
         cycle();
         check("hold_req", 32'(int_req), 32'h1);
         check("hold_cause", 32'(cause), 32'h0);
      end

      // reset in the middle of SAVE
      drive(8'h00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      cycle();
      check("reached_save", 32'(IAR_load), 32'h1);
      async_reset("rst_save");
      drive(8'hFF, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      cycle();
      check("post_rst_idle", 32'(int_req), 32'h0);

      // randomized traffic against the model
      for (int k = 0; k < 2000; k++) begin
         drive(8'($urandom),
               ($urandom_range(0, 15) == 0),
               $urandom,
               ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 3) == 0));
         cycle();
         if ($urandom_range(0, 299) == 0) begin
            async_reset("rst_rand");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
